life_row_engine: RTL and testbench

Streaming Game of Life generation engine. It accepts one generation as a sequence of WIDTH-bit rows over a valid/ready handshake and emits the next generation row by row. The survival/birth rule is programmable per frame, so any Life-like B/S rule is supported. It sits between the board memory reader and writer, replacing per-cell rule evaluation with a row-parallel pipeline.

---
 rtl/life_row_engine.sv | 176 +++++++++++++++++
 tb/tb_life_row_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_row_engine.sv
// -----------------------------------------------------------------------------
// life_row_engine
//   Streaming Game of Life generation engine. Rows of the current generation
//   arrive over a valid/ready handshake and the next generation leaves row by
//   row. The B/S rule comes from two 9-bit masks latched on the first row of
//   each frame, so any Life-like rule can be run.
//
//   Optional feature macro: LIFE_HWRAP_EN
//     defined   : columns wrap horizontally (column 0 <-> column WIDTH-1)
//     undefined : columns -1 and WIDTH are dead
//   Rows above the first and below the last row are always dead.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   in_valid_i     : input row valid
//   in_ready_o     : input row accepted when in_valid_i && in_ready_o
//   row_i          : current-generation row (bit i = column i)
//   in_last_i      : final row of the frame
//   birth_mask_i   : bit n -> dead cell with n live neighbours is born
//   survive_mask_i : bit n -> live cell with n live neighbours survives
//   out_valid_o    : output row valid
//   out_ready_i    : downstream accepts the output row
//   row_o          : next-generation row
//   out_last_o     : final output row of the frame
//   gen_count_o    : number of completed frames, wraps
// -----------------------------------------------------------------------------
module life_row_engine #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] row_i,
    input  logic             in_last_i,
    input  logic [8:0]       birth_mask_i,
    input  logic [8:0]       survive_mask_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] row_o,
    output logic             out_last_o,
    output logic [GEN_W-1:0] gen_count_o
);

    localparam int unsigned PAD_W = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] cur_q;
    logic [8:0]       birth_q;
    logic [8:0]       survive_q;

    logic             out_free;
    logic             accept;
    logic [WIDTH-1:0] eval_run;
    logic [WIDTH-1:0] eval_flush;

    // Add the horizontal border columns: index 0 is column -1, index WIDTH+1
    // is column WIDTH.
    function automatic logic [PAD_W-1:0] pad_row(input logic [WIDTH-1:0] r);
`ifdef LIFE_HWRAP_EN
        return {r[0], r, r[WIDTH-1]};
`else
        return {1'b0, r, 1'b0};
`endif
    endfunction

    // Apply the rule to every column of row c given the rows above (p) and below (n).
    function automatic logic [WIDTH-1:0] next_row(
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] n,
        input logic [8:0]       bm,
        input logic [8:0]       sm
    );
        logic [PAD_W-1:0] pe;
        logic [PAD_W-1:0] ce;
        logic [PAD_W-1:0] ne;
        logic [3:0]       sum;
        logic [WIDTH-1:0] res;
        pe  = pad_row(p);
        ce  = pad_row(c);
        ne  = pad_row(n);
        res = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum = 4'(pe[i]) + 4'(pe[i+1]) + 4'(pe[i+2])
                + 4'(ce[i])               + 4'(ce[i+2])
                + 4'(ne[i]) + 4'(ne[i+1]) + 4'(ne[i+2]);
            res[i] = c[i] ? sm[sum] : bm[sum];
        end
        return res;
    endfunction

    // Handshake qualifiers
    always_comb begin
        out_free   = !out_valid_o || out_ready_i;
        in_ready_o = !rst_i && ((state_q == S_IDLE) || ((state_q == S_RUN) && out_free));
        accept     = in_valid_i && in_ready_o;
    end

    // Row evaluation for the streaming case (next row arriving) and the
    // end-of-frame case (dead row below)
    always_comb begin
        eval_run   = next_row(prev_q, cur_q, row_i, birth_q, survive_q);
        eval_flush = next_row(prev_q, cur_q, '0, birth_q, survive_q);
    end

    // FSM, row window, output register and generation counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            cur_q       <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            out_valid_o <= 1'b0;
            row_o       <= '0;
            out_last_o  <= 1'b0;
            gen_count_o <= '0;
        end else begin
            // Retire the current output; a reload below takes precedence.
            if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
                if (out_last_o) begin
                    gen_count_o <= gen_count_o + GEN_W'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    // First row of a frame; a stalled last row from the
                    // previous frame stays untouched in the output register.
                    if (accept) begin
                        cur_q     <= row_i;
                        prev_q    <= '0;
                        birth_q   <= birth_mask_i;
                        survive_q <= survive_mask_i;
                        state_q   <= in_last_i ? S_FLUSH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        row_o       <= eval_run;
                        out_last_o  <= 1'b0;
                        out_valid_o <= 1'b1;
                        prev_q      <= cur_q;
                        cur_q       <= row_i;
                        if (in_last_i) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (out_free) begin
                        row_o       <= eval_flush;
                        out_last_o  <= 1'b1;
                        out_valid_o <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_row_engine.sv
// -----------------------------------------------------------------------------
// tb_life_row_engine
//   Scoreboard bench for life_row_engine at WIDTH=8. Tests push the expected
//   {last,row} pairs into a queue before driving a frame; a negedge monitor
//   pops and compares on every output handshake and also checks that a
//   stalled output holds steady.
// -----------------------------------------------------------------------------
module tb_life_row_engine;

    localparam int W = 8;
    localparam int G = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] row_i;
    logic         in_last_i;
    logic [8:0]   birth_mask_i;
    logic [8:0]   survive_mask_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] row_o;
    logic         out_last_o;
    logic [G-1:0] gen_count_o;

    int checks   = 0;
    int failures = 0;
    int exp_gen  = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    logic [W:0]   exp_q[$];
    logic [W-1:0] fr[0:15];
    int           fn;

    life_row_engine #(.WIDTH(W), .GEN_W(G)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .row_i          (row_i),
        .in_last_i      (in_last_i),
        .birth_mask_i   (birth_mask_i),
        .survive_mask_i (survive_mask_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .row_o          (row_o),
        .out_last_o     (out_last_o),
        .gen_count_o    (gen_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Downstream ready pattern
    always @(posedge clk_i) begin
        #1;
        if (ready_mode == 0)      out_ready_i = 1'b1;
        else if (ready_mode == 1) out_ready_i = 1'($urandom_range(0, 1));
        else                      out_ready_i = 1'b0;
    end

    // Scoreboard monitor
    logic         stall_q = 1'b0;
    logic [W-1:0] stall_row;
    logic         stall_last;
    always @(negedge clk_i) begin
        logic [W:0] e;
        if (rst_i === 1'b1) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (out_valid_o !== 1'b1 || row_o !== stall_row || out_last_o !== stall_last) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b row=%h last=%b, expected valid=1 row=%h last=%b",
                             out_valid_o, row_o, out_last_o, stall_row, stall_last);
                end
            end
            if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_row: got row=%h last=%b, expected no output", row_o, out_last_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last_o, row_o} !== e) begin
                        failures++;
                        $display("FAIL out_row: got row=%h last=%b, expected row=%h last=%b",
                                 row_o, out_last_o, e[W-1:0], e[W]);
                    end
                end
            end
            stall_q    = (out_valid_o === 1'b1) && (out_ready_i !== 1'b1);
            stall_row  = row_o;
            stall_last = out_last_o;
        end
    end

    // Independent reference: count neighbours cell by cell over frame fr[0:fn-1]
    function automatic logic [W-1:0] model_row(input int r, input logic [8:0] b, input logic [8:0] s);
        logic [W-1:0] res;
        int n, rr, cc;
        res = '0;
        for (int c = 0; c < W; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr == 0 && dc == 0) continue;
                    rr = r + dr;
                    cc = c + dc;
                    if (rr < 0 || rr >= fn) continue;
`ifdef LIFE_HWRAP_EN
                    cc = (cc + W) % W;
`else
                    if (cc < 0 || cc >= W) continue;
`endif
                    if (fr[rr][cc]) n++;
                end
            end
            res[c] = fr[r][c] ? s[n] : b[n];
        end
        return res;
    endfunction

    // Drive one row; called and returns at posedge+1
    task automatic send_row(input logic [W-1:0] r, input logic last);
        int t;
        in_valid_i = 1'b1;
        row_i      = r;
        in_last_i  = last;
        t = 0;
        @(negedge clk_i);
        while (in_ready_o !== 1'b1 && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready_o=%b after %0d cycles, expected 1", in_ready_o, t);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    // Drive fr[0:n-1]; optionally scramble the mask inputs after the first row
    task automatic drive_frame(input int n, input logic [8:0] b, input logic [8:0] s, input bit chg);
        birth_mask_i   = b;
        survive_mask_i = s;
        for (int r = 0; r < n; r++) begin
            send_row(fr[r], (r == n - 1));
            if (chg && r == 0) begin
                birth_mask_i   = ~b;
                survive_mask_i = ~s;
            end
        end
    endtask

    // Wait for the scoreboard to empty, then check the frame counter
    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 1000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d rows outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (gen_count_o !== G'(exp_gen)) begin
            failures++;
            $display("FAIL gen_count: got %0d, expected %0d", gen_count_o, exp_gen);
        end
    endtask

    task automatic load_blinker();
        fn = 3;
        fr[0] = 8'h00; fr[1] = 8'h1C; fr[2] = 8'h00;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0; in_last_i = 1'b0; row_i = '0;
        birth_mask_i = '0; survive_mask_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || row_o !== 8'h00 || out_last_o !== 1'b0 || gen_count_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b row=%h last=%b gen=%h, expected 0 0 0 0",
                     out_valid_o, row_o, out_last_o, gen_count_o);
        end
        checks++;
        if (in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b, expected 0", in_ready_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b, expected 1", in_ready_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_blinker();
        load_blinker();
        exp_q.push_back({1'b0, 8'h08});
        exp_q.push_back({1'b0, 8'h08});
        exp_q.push_back({1'b1, 8'h08});
        exp_gen++;
        drive_frame(3, 9'h008, 9'h00C, 1'b0);
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: got %b, expected 0", in_ready_o);
        end
        @(posedge clk_i);
        #1;
        wait_drain();
    endtask

    task automatic test_single_row();
        fn = 1;
        fr[0] = 8'hFF;
`ifdef LIFE_HWRAP_EN
        exp_q.push_back({1'b1, 8'hFF});
`else
        exp_q.push_back({1'b1, 8'h7E});
`endif
        exp_gen++;
        drive_frame(1, 9'h008, 9'h00C, 1'b0);
        wait_drain();
    endtask

    task automatic test_custom_rule();
        fn = 3;
        fr[0] = 8'h00; fr[1] = 8'h08; fr[2] = 8'h00;
        exp_q.push_back({1'b0, 8'h1C});
        exp_q.push_back({1'b0, 8'h14});
        exp_q.push_back({1'b1, 8'h1C});
        exp_gen++;
        drive_frame(3, 9'h002, 9'h000, 1'b0);
        wait_drain();
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        for (int k = 0; k < 4; k++) begin
            load_blinker();
            exp_q.push_back({1'b0, 8'h08});
            exp_q.push_back({1'b0, 8'h08});
            exp_q.push_back({1'b1, 8'h08});
            exp_gen++;
            drive_frame(3, 9'h008, 9'h00C, 1'b1);
            wait_drain();
        end
        ready_mode = 0;
    endtask

    // Frames sent without draining in between, under random backpressure
    task automatic test_back_to_back();
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            logic [8:0] b, s;
            fn = $urandom_range(1, 6);
            for (int r = 0; r < fn; r++) fr[r] = W'($urandom);
            b = 9'($urandom);
            s = 9'($urandom);
            for (int r = 0; r < fn; r++) exp_q.push_back({(r == fn - 1) ? 1'b1 : 1'b0, model_row(r, b, s)});
            exp_gen++;
            drive_frame(fn, b, s, 1'b1);
        end
        wait_drain();
        ready_mode = 0;
    endtask

    task automatic test_mid_frame_reset();
        ready_mode = 2;
        @(posedge clk_i);
        #2;
        send_row(8'h00, 1'b0);
        send_row(8'h1C, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_gen = 0;
        ready_mode = 0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || gen_count_o !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_clear: got valid=%b gen=%0d, expected 0 0", out_valid_o, gen_count_o);
        end
        @(posedge clk_i);
        #1;
        load_blinker();
        exp_q.push_back({1'b0, 8'h08});
        exp_q.push_back({1'b0, 8'h08});
        exp_q.push_back({1'b1, 8'h08});
        exp_gen++;
        drive_frame(3, 9'h008, 9'h00C, 1'b0);
        wait_drain();
    endtask

    initial begin
        out_ready_i = 1'b1;
        test_reset();
        test_blinker();
        test_single_row();
        test_custom_rule();
        test_backpressure();
        test_back_to_back();
        test_mid_frame_reset();
        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
